vecadd_arbiter: RTL

VECADD_ARBITER -- requirements
Module: vecadd_arbiter

---
 rtl/vecadd_arbiter_if.sv | 38 +++
 rtl/vecadd_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/vecadd_arbiter_if.sv
// Request, adder and result signals for the two-requester vector-add arbiter.
// slave is the arbiter's view; master is the surrounding system (requesters plus adder).
interface vecadd_arbiter_if;
    logic         en;
    logic         req0_valid;
    logic         req0_ready;
    logic [511:0] req0_a;
    logic [511:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [511:0] req1_a;
    logic [511:0] req1_b;
    logic         add_in_valid;
    logic [511:0] add_a;
    logic [511:0] add_b;
    logic         add_out_valid;
    logic [511:0] add_out_data;
    logic         res_valid;
    logic         res_id;
    logic [511:0] res_data;
    logic [31:0]  issue_cnt;
    logic         err;
    logic         idle;

    modport slave (
        input  en, req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               add_out_valid, add_out_data,
        output req0_ready, req1_ready, add_in_valid, add_a, add_b,
               res_valid, res_id, res_data, issue_cnt, err, idle
    );

    modport master (
        output en, req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               add_out_valid, add_out_data,
        input  req0_ready, req1_ready, add_in_valid, add_a, add_b,
               res_valid, res_id, res_data, issue_cnt, err, idle
    );
endinterface

// File: rtl/vecadd_arbiter.sv
// Round-robin arbiter feeding a fixed-latency 16-lane vector adder; a tag FIFO
// tracks which requester owns each in-flight operation so results route back in order.
module vecadd_arbiter #(
    parameter int ADD_LAT   = 12,
    parameter int TAG_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    vecadd_arbiter_if.slave bus
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH + 1);

    if (ADD_LAT < 1 || ADD_LAT > 31) begin : g_bad_lat
        $error("vecadd_arbiter: ADD_LAT must be within 1..31");
    end
    if (TAG_DEPTH < ADD_LAT + 1 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vecadd_arbiter: TAG_DEPTH must be a power of two and exceed ADD_LAT");
    end

    logic          last_grant;
    logic [CW-1:0] tag_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          tag_mem [TAG_DEPTH];

    logic tag_full;
    logic tag_empty;
    logic grant0;
    logic grant1;
    logic hs0;
    logic hs1;
    logic push;
    logic pop;

    // Grant ignores en and FIFO state so the round-robin pointer is never disturbed by stalls.
    always_comb begin
        tag_full  = (tag_cnt == CW'(TAG_DEPTH));
        tag_empty = (tag_cnt == '0);
        grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
        hs0       = bus.req0_valid && grant0 && bus.en && !tag_full;
        hs1       = bus.req1_valid && grant1 && bus.en && !tag_full;
        push      = hs0 || hs1;
        pop       = bus.add_out_valid && !tag_empty;
    end

    assign bus.req0_ready = grant0 && bus.en && !tag_full;
    assign bus.req1_ready = grant1 && bus.en && !tag_full;
    assign bus.idle       = tag_empty && !bus.add_in_valid && !bus.res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant       <= 1'b1;
            tag_cnt          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.add_in_valid <= 1'b0;
            bus.add_a        <= '0;
            bus.add_b        <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_id       <= 1'b0;
            bus.res_data     <= '0;
            bus.issue_cnt    <= '0;
            bus.err          <= 1'b0;
        end else begin
            bus.add_in_valid <= push;
            bus.res_valid    <= bus.add_out_valid;

            if (hs0) begin
                last_grant <= 1'b0;
                bus.add_a  <= bus.req0_a;
                bus.add_b  <= bus.req0_b;
            end else if (hs1) begin
                last_grant <= 1'b1;
                bus.add_a  <= bus.req1_a;
                bus.add_b  <= bus.req1_b;
            end

            if (push) begin
                wr_ptr        <= wr_ptr + PW'(1);
                bus.issue_cnt <= bus.issue_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (push && !pop) begin
                tag_cnt <= tag_cnt + CW'(1);
            end else if (pop && !push) begin
                tag_cnt <= tag_cnt - CW'(1);
            end

            // A result with no matching tag is still delivered, attributed to requester 0.
            if (bus.add_out_valid) begin
                bus.res_data <= bus.add_out_data;
                bus.res_id   <= tag_empty ? 1'b0 : tag_mem[rd_ptr];
                if (tag_empty) begin
                    bus.err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= hs1;
        end
    end
endmodule
